// File: rtl/cache_bus1_arbiter.sv
// ---------------------------------------------------------------------------
// cache_bus1_arbiter
//
// Shares the CPU-side cache bus (A1 address, D1 data, C1 command) between two
// requesters. A winner is picked round-robin. The arbiter then runs the
// two-cycle command/address phase, releases the bus, and waits for the cache
// to answer with C1 = RESPONSE. It captures any read data and returns a
// one-cycle done pulse to the requester that owns the bus.
//
// Ports
//   CLK            clock, all state updates on the rising edge
//   RESET          asynchronous, active-low reset
//   req[1:0]       request level per requester
//   cmd0/cmd1      C1 command code per requester
//   addr0/addr1    byte address per requester (tag+set bits, then offset)
//   wdata0/wdata1  write data per requester
//   gnt[1:0]       one-hot, high while a requester owns the bus
//   done[1:0]      one-cycle completion pulse per requester
//   err            valid with done, 1 = response timeout
//   rdata[31:0]    read data, valid with done
//   busy           arbiter is not idle
//   A1_WIRE        shared address bus (tri-state)
//   D1_WIRE        shared data bus (tri-state)
//   C1_WIRE        shared command bus (tri-state)
// ---------------------------------------------------------------------------
module cache_bus1_arbiter #(
  parameter int ADDR1_W  = 15,
  parameter int OFFSET_W = 4,
  parameter int DATA1_W  = 16,
  parameter int CTR1_W   = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [1:0]                   req,
  input  logic [CTR1_W-1:0]            cmd0,
  input  logic [CTR1_W-1:0]            cmd1,
  input  logic [ADDR1_W+OFFSET_W-1:0]  addr0,
  input  logic [ADDR1_W+OFFSET_W-1:0]  addr1,
  input  logic [31:0]                  wdata0,
  input  logic [31:0]                  wdata1,
  output logic [1:0]                   gnt,
  output logic [1:0]                   done,
  output logic                         err,
  output logic [31:0]                  rdata,
  output logic                         busy,
  inout  wire  [ADDR1_W-1:0]           A1_WIRE,
  inout  wire  [DATA1_W-1:0]           D1_WIRE,
  inout  wire  [CTR1_W-1:0]            C1_WIRE
);

  localparam int FULL_AW = ADDR1_W + OFFSET_W;
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  // Command codes on C1. RESPONSE shares the WRITE32 code but is only
  // ever driven by the cache while the arbiter has released the bus.
  localparam logic [CTR1_W-1:0] CMD_NOP      = CTR1_W'(0);
  localparam logic [CTR1_W-1:0] CMD_READ8    = CTR1_W'(1);
  localparam logic [CTR1_W-1:0] CMD_READ16   = CTR1_W'(2);
  localparam logic [CTR1_W-1:0] CMD_READ32   = CTR1_W'(3);
  localparam logic [CTR1_W-1:0] CMD_WRITE8   = CTR1_W'(5);
  localparam logic [CTR1_W-1:0] CMD_WRITE16  = CTR1_W'(6);
  localparam logic [CTR1_W-1:0] CMD_WRITE32  = CTR1_W'(7);
  localparam logic [CTR1_W-1:0] CMD_RESPONSE = CTR1_W'(7);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD1  = 3'd1;
  localparam logic [2:0] ST_CMD2  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP2 = 3'd4;
  localparam logic [2:0] ST_TURN  = 3'd5;

  logic [2:0]          state;
  logic                last_grant;
  logic [CTR1_W-1:0]   cmd_q;
  logic [OFFSET_W-1:0] off_q;
  logic [15:0]         whi_q;
  logic [TO_W-1:0]     to_cnt;

  // Bus drivers: every value put on a shared wire comes from a register,
  // so the cache (sampling on the falling edge) always sees stable data.
  logic [ADDR1_W-1:0]  a1_q;
  logic                a1_oe;
  logic [DATA1_W-1:0]  d1_q;
  logic                d1_oe;
  logic [CTR1_W-1:0]   c1_q;
  logic                c1_oe;

  logic                pick;
  logic [CTR1_W-1:0]   sel_cmd;
  logic [FULL_AW-1:0]  sel_addr;
  logic [31:0]         sel_wdata;

  function automatic logic is_write(input logic [CTR1_W-1:0] c);
    return (c == CMD_WRITE8) || (c == CMD_WRITE16) || (c == CMD_WRITE32);
  endfunction

  assign A1_WIRE = a1_oe ? a1_q : 'z;
  assign D1_WIRE = d1_oe ? d1_q : 'z;
  assign C1_WIRE = c1_oe ? c1_q : 'z;

  assign busy = (state != ST_IDLE);

  // Round-robin pick: a lone requester always wins; when both request,
  // the one that did not win last time goes first.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) begin
      pick = ~last_grant;
    end else if (req[1]) begin
      pick = 1'b1;
    end
    sel_cmd   = pick ? cmd1   : cmd0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  // Main sequencer. done and err default low every cycle so they can only
  // ever be single-cycle pulses; done copies gnt, so it can never be high
  // for both requesters at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      gnt        <= 2'b00;
      done       <= 2'b00;
      err        <= 1'b0;
      rdata      <= 32'h0;
      last_grant <= 1'b1;
      cmd_q      <= CMD_NOP;
      off_q      <= '0;
      whi_q      <= 16'h0;
      to_cnt     <= '0;
      a1_q       <= '0;
      a1_oe      <= 1'b0;
      d1_q       <= '0;
      d1_oe      <= 1'b0;
      c1_q       <= '0;
      c1_oe      <= 1'b0;
    end else begin
      done <= 2'b00;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            cmd_q      <= sel_cmd;
            off_q      <= sel_addr[OFFSET_W-1:0];
            whi_q      <= sel_wdata[31:16];
            gnt        <= pick ? 2'b10 : 2'b01;
            last_grant <= pick;
            if (sel_cmd == CMD_NOP) begin
              // Nothing to send to the cache: complete immediately.
              done  <= pick ? 2'b10 : 2'b01;
              state <= ST_TURN;
            end else begin
              c1_q  <= sel_cmd;
              c1_oe <= 1'b1;
              a1_q  <= sel_addr[FULL_AW-1:OFFSET_W];
              a1_oe <= 1'b1;
              d1_q  <= DATA1_W'(sel_wdata[15:0]);
              d1_oe <= is_write(sel_cmd);
              state <= ST_CMD1;
            end
          end
        end

        ST_CMD1: begin
          // Second address cycle carries only the line offset; the high
          // data half is only meaningful for WRITE32.
          a1_q  <= ADDR1_W'(off_q);
          d1_q  <= DATA1_W'(whi_q);
          d1_oe <= (cmd_q == CMD_WRITE32);
          state <= ST_CMD2;
        end

        ST_CMD2: begin
          a1_oe  <= 1'b0;
          d1_oe  <= 1'b0;
          c1_oe  <= 1'b0;
          to_cnt <= '0;
          state  <= ST_WAIT;
        end

        ST_WAIT: begin
          // A response seen on the same edge as the timeout wins.
          if (C1_WIRE == CMD_RESPONSE) begin
            case (cmd_q)
              CMD_READ8: begin
                rdata <= 32'(D1_WIRE[7:0]);
                done  <= gnt;
                state <= ST_TURN;
              end
              CMD_READ16: begin
                rdata <= 32'(D1_WIRE[15:0]);
                done  <= gnt;
                state <= ST_TURN;
              end
              CMD_READ32: begin
                rdata[15:0] <= D1_WIRE[15:0];
                state       <= ST_RESP2;
              end
              default: begin
                done  <= gnt;
                state <= ST_TURN;
              end
            endcase
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            done  <= gnt;
            err   <= 1'b1;
            state <= ST_TURN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_RESP2: begin
          rdata[31:16] <= D1_WIRE[15:0];
          done         <= gnt;
          state        <= ST_TURN;
        end

        ST_TURN: begin
          // Bus turnaround: ownership ends here, a new grant can be made
          // on the next edge.
          gnt   <= 2'b00;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus1_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_bus1_arbiter
//
// Self-checking bench for cache_bus1_arbiter. A small cache model answers on
// the shared buses; the expected winner, latency, bus contents and read data
// come from a behavioural model of the arbitration and transfer rules.
// Shared buses are tri0 nets so a released bus reads as zero.
// ---------------------------------------------------------------------------
module tb_cache_bus1_arbiter;

  logic        CLK;
  logic        RESET;
  logic [1:0]  req;
  logic [2:0]  cmd0, cmd1;
  logic [18:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  gnt, done;
  logic        err;
  logic [31:0] rdata;
  logic        busy;
  tri0  [14:0] a1_w;
  tri0  [15:0] d1_w;
  tri0  [2:0]  c1_w;

  // Cache-side drivers
  logic        cc_en, cd_en;
  logic [2:0]  cc;
  logic [15:0] cd;

  assign c1_w = cc_en ? cc : 3'bz;
  assign d1_w = cd_en ? cd : 16'bz;

  int n_cmp;
  int n_bad;

  // Reference model state
  int          last_win;
  logic [31:0] m_rdata;

  typedef struct {
    bit          granted;
    int          wait_cycles;
    logic [1:0]  gnt;
    logic [2:0]  c1a, c1b, c1r;
    logic [14:0] a1a, a1b, a1r;
    logic [15:0] d1a, d1b, d1r;
    int          done_edge;
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  done_after;
    logic [1:0]  gnt_after;
    logic        busy_after;
  } obs_t;

  cache_bus1_arbiter dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .req     (req),
    .cmd0    (cmd0),
    .cmd1    (cmd1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .rdata   (rdata),
    .busy    (busy),
    .A1_WIRE (a1_w),
    .D1_WIRE (d1_w),
    .C1_WIRE (c1_w)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Round-robin rule: a lone requester wins; on a tie the one that did not
  // win last goes first.
  function automatic int pick_winner(input logic [1:0] r, input int last);
    if (r == 2'b11) return (last == 0) ? 1 : 0;
    return r[1] ? 1 : 0;
  endfunction

  // Read data after a completed transaction.
  function automatic logic [31:0] next_rdata(input logic [2:0] c, input logic [31:0] cur,
                                             input logic [15:0] lo, input logic [15:0] hi);
    case (c)
      3'd1:    return {24'h0, lo[7:0]};
      3'd2:    return {16'h0, lo};
      3'd3:    return {hi, lo};
      default: return cur;
    endcase
  endfunction

  // Drives the cache side of one transaction and records what the DUT did.
  // Edge numbering: the grant edge is 0; done_edge is the edge after which
  // done was seen high.
  task automatic run_txn(input bit is_r32, input bit respond, input int dly,
                         input logic [15:0] lo, input logic [15:0] hi,
                         input bit drop_req, output obs_t o);
    int n;
    bit stop;
    o.granted = 0; o.wait_cycles = 0; o.gnt = 2'b00;
    o.c1a = 0; o.c1b = 0; o.c1r = 0; o.a1a = 0; o.a1b = 0; o.a1r = 0;
    o.d1a = 0; o.d1b = 0; o.d1r = 0;
    o.done_edge = -1; o.done = 2'b00; o.err = 1'b0; o.rdata = 32'h0;
    o.done_after = 2'b00; o.gnt_after = 2'b00; o.busy_after = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (gnt != 2'b00) begin
        o.granted = 1;
        o.wait_cycles = i + 1;
        break;
      end
    end
    if (!o.granted) return;
    o.gnt = gnt; o.c1a = c1_w; o.a1a = a1_w; o.d1a = d1_w;
    if (drop_req) req = 2'b00;
    n = 0;
    if (done == 2'b00) begin
      @(posedge CLK); #1; n = 1;
      o.c1b = c1_w; o.a1b = a1_w; o.d1b = d1_w;
      @(posedge CLK); #1; n = 2;
      o.c1r = c1_w; o.a1r = a1_w; o.d1r = d1_w;
      stop = 0;
      while (!stop && n < 300) begin
        if (done != 2'b00) begin
          stop = 1;
        end else begin
          if (respond && n == 2 + dly) begin
            cc_en = 1; cc = 3'd7; cd_en = 1; cd = lo;
          end else if (respond && is_r32 && n == 3 + dly) begin
            cc_en = 0; cd_en = 1; cd = hi;
          end else if (respond && n < 2 + dly) begin
            cc_en = 1; cc = 3'($urandom_range(0, 6)); cd_en = 0;
          end else begin
            cc_en = 0; cd_en = 0;
          end
          @(posedge CLK); #1; n++;
        end
      end
    end
    cc_en = 0; cd_en = 0;
    if (done != 2'b00) begin
      o.done_edge = n; o.done = done; o.err = err; o.rdata = rdata;
    end
    @(posedge CLK); #1;
    o.done_after = done; o.gnt_after = gnt; o.busy_after = busy;
  endtask

  task automatic test_reset();
    RESET = 1'b0; req = 2'b00;
    cmd0 = 3'd0; cmd1 = 3'd0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    cc_en = 0; cd_en = 0; cc = 0; cd = 0;
    last_win = 1; m_rdata = 32'h0;
    #12;
    n_cmp++;
    if ({gnt, done, err, busy} !== 6'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs gnt/done/err/busy=%b required 000000", {gnt, done, err, busy});
    end
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_rdata got %h required 00000000", rdata);
    end
    n_cmp++;
    if ({a1_w, d1_w, c1_w} !== 34'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_bus_release got a1=%h d1=%h c1=%h required all released", a1_w, d1_w, c1_w);
    end
    @(negedge CLK); RESET = 1'b1;
  endtask

  task automatic test_round_robin();
    obs_t o;
    int w;
    req = 2'b11; cmd0 = 3'd1; cmd1 = 3'd1; addr0 = 19'h0ABC5; addr1 = 19'h1F00E;
    w = pick_winner(req, last_win);
    run_txn(0, 1, 0, 16'h3C5A, 16'h0, 0, o);
    m_rdata = next_rdata(3'd1, m_rdata, 16'h3C5A, 16'h0);
    last_win = w;
    n_cmp++;
    if (o.gnt !== ((w == 1) ? 2'b10 : 2'b01)) begin
      n_bad++;
      $display("[TB] FAIL rr_first_gnt got %b required %b", o.gnt, (w == 1) ? 2'b10 : 2'b01);
    end
    n_cmp++;
    if (o.rdata !== m_rdata || o.done_edge != 3) begin
      n_bad++;
      $display("[TB] FAIL rr_first_read got rdata=%h edge=%0d required rdata=%h edge=3", o.rdata, o.done_edge, m_rdata);
    end
    w = pick_winner(req, last_win);
    run_txn(0, 1, 1, 16'h77E1, 16'h0, 0, o);
    m_rdata = next_rdata(3'd1, m_rdata, 16'h77E1, 16'h0);
    last_win = w;
    n_cmp++;
    if (o.gnt !== 2'b10 || o.wait_cycles != 1 || o.done !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL rr_second_gnt got gnt=%b wait=%0d done=%b required gnt=10 wait=1 done=10", o.gnt, o.wait_cycles, o.done);
    end
    n_cmp++;
    if (o.rdata !== m_rdata || o.done_edge != 4) begin
      n_bad++;
      $display("[TB] FAIL rr_second_read got rdata=%h edge=%0d required rdata=%h edge=4", o.rdata, o.done_edge, m_rdata);
    end
    req = 2'b00;
  endtask

  task automatic test_invalidate();
    obs_t o;
    req = 2'b01; cmd0 = 3'd4; addr0 = 19'h00012;
    run_txn(0, 1, 1, 16'h1111, 16'h0, 0, o);
    last_win = 0;
    req = 2'b00;
    n_cmp++;
    if ({o.c1a, o.a1a, o.d1a} !== {3'd4, 15'h0001, 16'h0} ||
        {o.c1b, o.a1b, o.d1b} !== {3'd4, 15'h0002, 16'h0}) begin
      n_bad++;
      $display("[TB] FAIL inval_cmd_phase got c1=%0d/%0d a1=%h/%h d1=%h/%h required c1=4/4 a1=0001/0002 d1 released",
               o.c1a, o.c1b, o.a1a, o.a1b, o.d1a, o.d1b);
    end
    n_cmp++;
    if ({o.c1r, o.a1r, o.d1r} !== 34'h0) begin
      n_bad++;
      $display("[TB] FAIL inval_release got c1=%h a1=%h d1=%h required all released", o.c1r, o.a1r, o.d1r);
    end
    n_cmp++;
    if (o.done !== 2'b01 || o.err !== 1'b0 || o.rdata !== m_rdata || o.done_edge != 4) begin
      n_bad++;
      $display("[TB] FAIL inval_done got done=%b err=%b rdata=%h edge=%0d required done=01 err=0 rdata=%h edge=4",
               o.done, o.err, o.rdata, o.done_edge, m_rdata);
    end
    n_cmp++;
    if (o.done_after !== 2'b00 || o.gnt_after !== 2'b00 || o.busy_after !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL inval_after got done=%b gnt=%b busy=%b required 00 00 0", o.done_after, o.gnt_after, o.busy_after);
    end
  endtask

  task automatic test_read32();
    obs_t o;
    req = 2'b01; cmd0 = 3'd3; addr0 = 19'h1A5C3;
    run_txn(1, 1, 0, 16'hBEEF, 16'hDEAD, 1, o);
    m_rdata = 32'hDEADBEEF;
    last_win = 0;
    n_cmp++;
    if (o.a1a !== 15'h1A5C || o.a1b !== 15'h0003 || o.c1a !== 3'd3) begin
      n_bad++;
      $display("[TB] FAIL read32_addr got a1=%h/%h c1=%0d required a1=1a5c/0003 c1=3", o.a1a, o.a1b, o.c1a);
    end
    n_cmp++;
    if (o.rdata !== m_rdata || o.done !== 2'b01 || o.done_edge != 4) begin
      n_bad++;
      $display("[TB] FAIL read32_data got rdata=%h done=%b edge=%0d required rdata=%h done=01 edge=4",
               o.rdata, o.done, o.done_edge, m_rdata);
    end
  endtask

  task automatic test_write32();
    obs_t o;
    req = 2'b10; cmd1 = 3'd7; addr1 = 19'h2468A; wdata1 = 32'h12345678;
    run_txn(0, 1, 2, 16'hCAFE, 16'h0, 0, o);
    last_win = 1;
    req = 2'b00;
    n_cmp++;
    if (o.d1a !== 16'h5678 || o.d1b !== 16'h1234 || o.d1r !== 16'h0) begin
      n_bad++;
      $display("[TB] FAIL write32_data_bus got d1=%h/%h/%h required 5678/1234/released", o.d1a, o.d1b, o.d1r);
    end
    n_cmp++;
    if (o.done !== 2'b10 || o.rdata !== m_rdata || o.done_edge != 5 || o.err !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL write32_done got done=%b rdata=%h edge=%0d err=%b required done=10 rdata=%h edge=5 err=0",
               o.done, o.rdata, o.done_edge, o.err, m_rdata);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    req = 2'b01; cmd0 = 3'd2; addr0 = 19'h01234;
    run_txn(0, 0, 0, 16'h0, 16'h0, 0, o);
    last_win = 0;
    n_cmp++;
    if (o.done !== 2'b01 || o.err !== 1'b1 || o.done_edge != 257 || o.rdata !== m_rdata) begin
      n_bad++;
      $display("[TB] FAIL timeout_abort got done=%b err=%b edge=%0d rdata=%h required done=01 err=1 edge=257 rdata=%h",
               o.done, o.err, o.done_edge, o.rdata, m_rdata);
    end
    cmd0 = 3'd0;
    run_txn(0, 0, 0, 16'h0, 16'h0, 0, o);
    req = 2'b00;
    n_cmp++;
    if (o.wait_cycles != 1 || o.done_edge != 0 || o.done !== 2'b01 || o.err !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL timeout_next_nop got wait=%0d edge=%0d done=%b err=%b required wait=1 edge=0 done=01 err=0",
               o.wait_cycles, o.done_edge, o.done, o.err);
    end
    n_cmp++;
    if ({o.c1a, o.a1a, o.d1a} !== 34'h0) begin
      n_bad++;
      $display("[TB] FAIL nop_no_bus got c1=%h a1=%h d1=%h required all released", o.c1a, o.a1a, o.d1a);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit got;
    bit done_seen;
    req = 2'b01; cmd0 = 3'd2; addr0 = 19'h05559;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge CLK); #1;
      if (gnt != 2'b00) got = 1;
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (!got || a1_w !== 15'h0009) begin
      n_bad++;
      $display("[TB] FAIL resetmid_cmd1 got granted=%0d a1=%h required granted=1 a1=0009", got, a1_w);
    end
    #2 RESET = 1'b0;
    #1;
    n_cmp++;
    if ({a1_w, d1_w, c1_w} !== 34'h0 || gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00 || rdata !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL resetmid_release got a1=%h d1=%h c1=%h gnt=%b busy=%b done=%b rdata=%h required all zero",
               a1_w, d1_w, c1_w, gnt, busy, done, rdata);
    end
    req = 2'b11; cmd0 = 3'd1; cmd1 = 3'd1; addr0 = 19'h00100; addr1 = 19'h00200;
    last_win = 1; m_rdata = 32'h0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (done != 2'b00) done_seen = 1;
    end
    n_cmp++;
    if (done_seen) begin
      n_bad++;
      $display("[TB] FAIL resetmid_no_done got done pulse during reset required none");
    end
    @(negedge CLK); RESET = 1'b1;
    run_txn(0, 1, 0, 16'hA0C3, 16'h0, 0, o);
    m_rdata = 32'h000000C3;
    last_win = 0;
    req = 2'b00;
    n_cmp++;
    if (o.gnt !== 2'b01 || o.wait_cycles != 1 || o.rdata !== m_rdata || o.done !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL resetmid_restart got gnt=%b wait=%0d rdata=%h done=%b required gnt=01 wait=1 rdata=%h done=01",
               o.gnt, o.wait_cycles, o.rdata, o.done, m_rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int w, dly, exp_edge;
    logic [2:0] c;
    logic [18:0] a;
    logic [31:0] wd;
    logic [15:0] lo, hi;
    logic [1:0] exp_gnt;
    logic [33:0] exp_a, exp_b;
    for (int it = 0; it < 24; it++) begin
      req    = 2'($urandom_range(1, 3));
      cmd0   = 3'($urandom_range(0, 7));
      cmd1   = 3'($urandom_range(0, 7));
      addr0  = 19'($urandom);
      addr1  = 19'($urandom);
      wdata0 = $urandom;
      wdata1 = $urandom;
      dly    = $urandom_range(0, 4);
      lo     = 16'($urandom);
      hi     = 16'($urandom);
      w  = pick_winner(req, last_win);
      c  = (w == 1) ? cmd1 : cmd0;
      a  = (w == 1) ? addr1 : addr0;
      wd = (w == 1) ? wdata1 : wdata0;
      exp_gnt = (w == 1) ? 2'b10 : 2'b01;
      run_txn(c == 3'd3, 1, dly, lo, hi, it[0], o);
      if (c == 3'd0) begin
        exp_edge = 0;
        exp_a = 34'h0;
        exp_b = 34'h0;
      end else begin
        exp_edge = 3 + dly + ((c == 3'd3) ? 1 : 0);
        exp_a = {c, a[18:4], (c >= 3'd5) ? wd[15:0] : 16'h0};
        exp_b = {c, 11'h0, a[3:0], (c == 3'd7) ? wd[31:16] : 16'h0};
      end
      m_rdata = next_rdata(c, m_rdata, lo, hi);
      last_win = w;
      n_cmp++;
      if (o.gnt !== exp_gnt || o.done !== exp_gnt || o.err !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL rand%0d_owner got gnt=%b done=%b err=%b required gnt=%b done=%b err=0",
                 it, o.gnt, o.done, o.err, exp_gnt, exp_gnt);
      end
      n_cmp++;
      if ({o.c1a, o.a1a, o.d1a} !== exp_a || {o.c1b, o.a1b, o.d1b} !== exp_b) begin
        n_bad++;
        $display("[TB] FAIL rand%0d_bus cmd=%0d got %h/%h required %h/%h",
                 it, c, {o.c1a, o.a1a, o.d1a}, {o.c1b, o.a1b, o.d1b}, exp_a, exp_b);
      end
      n_cmp++;
      if (o.done_edge != exp_edge || o.rdata !== m_rdata) begin
        n_bad++;
        $display("[TB] FAIL rand%0d_result cmd=%0d got edge=%0d rdata=%h required edge=%0d rdata=%h",
                 it, c, o.done_edge, o.rdata, exp_edge, m_rdata);
      end
      n_cmp++;
      if (o.done_after !== 2'b00 || o.gnt_after !== 2'b00 || o.busy_after !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL rand%0d_turn got done=%b gnt=%b busy=%b required 00 00 0",
                 it, o.done_after, o.gnt_after, o.busy_after);
      end
    end
    req = 2'b00;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_round_robin();
    test_invalidate();
    test_read32();
    test_write32();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_bus1_arbiter.md
Name: cache_bus1_arbiter

Overview:
- Shares the CPU-side cache bus (A1/D1/C1) between two requesters.
- Sequences the two-cycle command/address phase, releases the bus, and waits for the cache's C1_RESPONSE.
- Captures read data, then returns a one-cycle completion pulse to the owning requester.
- Sits between the CPU-side clients and the Cache instance; the cache is unchanged.

Parameters:
- ADDR1_W, 15, A1 bus width (tag+set bits).
- OFFSET_W, 4, line offset bits sent in the second address cycle.
- DATA1_W, 16, D1 bus width.
- CTR1_W, 3, C1 bus width.
- TIMEOUT, 255, WAIT_RESP cycles before abort.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- req  in  2  per-requester request level
- cmd0, cmd1  in  3 each  C1 command code (NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7; RESPONSE=7 from cache)
- addr0, addr1  in  ADDR1_W+OFFSET_W each  byte address
- wdata0, wdata1  in  32 each  write data
- gnt  out  2  one-hot, high while requester owns the bus
- done  out  2  one-cycle completion pulse per requester
- err  out  1  valid with done; 1 = timeout
- rdata  out  32  read data, valid with done
- busy  out  1  state != IDLE
- A1_WIRE  inout  ADDR1_W  shared address bus
- D1_WIRE  inout  DATA1_W  shared data bus
- C1_WIRE  inout  CTR1_W  shared command bus

Behaviour:
- Reset (async, immediate) sets:
  - state=IDLE; gnt=0, done=0, err=0, rdata=0, busy=0.
  - A1/D1/C1 drivers all 'z; last_grant=1; timeout counter=0.
- Reset mid-transaction releases the buses at once; no done is issued.
- Bus drives come only from registers; the cache samples on the falling edge.
- IDLE:
  - On the edge where req!=0, select one requester round-robin: the requester that was not last_grant wins when both request.
  - Latch its cmd/addr/wdata and set gnt and last_grant.
  - If the latched cmd is NOP: go to TURN and pulse done with err=0; no bus activity.
  - Otherwise drive:
    - C1=cmd.
    - A1=addr[ADDR1_W+OFFSET_W-1:OFFSET_W].
    - D1=wdata[15:0] for WRITE*, 'z otherwise.
  - Next state CMD1.
- CMD1 (next edge):
  - C1 held.
  - A1={zeros, addr[OFFSET_W-1:0]}.
  - D1=wdata[31:16] for WRITE32, 'z otherwise.
  - Next state CMD2.
- CMD2 (next edge): A1/D1/C1 all 'z; clear timeout counter; next state WAIT_RESP.
- WAIT_RESP: sample C1_WIRE each edge.
  - ==7:
    - READ8/16: capture D1, zero-extended into rdata (READ8 keeps only D1[7:0]).
    - READ32: capture low half, go to RESP2.
    - All other commands: rdata unchanged, pulse done, go to TURN.
  - Counter reaches TIMEOUT: pulse done with err=1, go to TURN. Buses are already released.
- RESP2 (next edge): rdata[31:16]=D1; pulse done; go to TURN.
- TURN: one bus turnaround cycle; gnt cleared; next IDLE. A new grant is possible on the following edge.
- A requester dropping req mid-transaction is ignored; done is still pulsed.
- done is never asserted for both requesters at once.
- C1 value 7 seen during CMD1/CMD2 is ignored.
- Latency, grant at edge k:
  - Bus released after k+2.
  - Earliest response sampled at k+3; done high for the cycle after k+3, or after k+4 for READ32.

Test Plan:
- After reset: assert req=01, cmd0=INVALIDATE_LINE, addr0=0x00012 -> C1=4, A1=0x0001 for one cycle, then A1=0x2; then all 'z. Cache responds with 7 -> done=01, err=0.
- req=11 simultaneously, both READ8 -> requester 0 served first. While req0 is held, requester 1 is granted next: gnt sequence 01 then 10.
- READ32 at addr 0x1A5C3, cache returns D1=0xBEEF then 0xDEAD -> rdata=0xDEADBEEF, done pulse after second word.
- WRITE32 wdata=0x12345678 -> D1=0x5678 in cycle 1, 0x1234 in cycle 2, then 'z; done on response, rdata unchanged.
- No response for 255 cycles -> done pulse with err=1; next request accepted two edges later.
- RESET low during CMD1 -> A1/D1/C1 'z immediately, gnt=0, no done. After release, a pending req restarts with requester 0 priority.
